// File: rtl/uart_cmd_responder_if.sv
// Handshake bundle for uart_cmd_responder: RX byte stream, TX byte stream, Avalon-MM master.
// master = responder side, slave = PHY/bus environment side.
interface uart_cmd_responder_if;
    logic        in_ready;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_error;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [17:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;

    modport master (
        output in_ready, out_valid, out_data, avm_address, avm_read, avm_write,
        output avm_writedata, avm_byteenable, busy,
        input  in_valid, in_data, in_error, out_ready, avm_readdata, avm_waitrequest
    );

    modport slave (
        input  in_ready, out_valid, out_data, avm_address, avm_read, avm_write,
        input  avm_writedata, avm_byteenable, busy,
        output in_valid, in_data, in_error, out_ready, avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART command responder: parses 'W'/'R' frames, runs one Avalon-MM access, returns ACK/NAK/data.
// Optional trailing-checksum support is enabled by defining UART_CMD_RESPONDER_CHECKSUM_EN.
module uart_cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  ACK_CODE       = 8'h06,
    parameter logic [7:0]  NAK_CODE       = 8'h15
) (
    input logic                  clock_sig,
    input logic                  reset_sig,
    uart_cmd_responder_if.master bus_io
);
    localparam logic [23:0] TimeoutLoad = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
        StChk,
`endif
        StBus,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] timer_q, timer_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  left_q, left_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [7:0]  rd_tail;
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    logic rx_state, accept;
    assign rx_state = (state_q != StBus) && (state_q != StResp);
    assign accept   = rx_state && bus_io.in_valid;

`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
    assign rd_tail = bus_io.avm_readdata[31:24] ^ bus_io.avm_readdata[23:16] ^
                     bus_io.avm_readdata[15:8]  ^ bus_io.avm_readdata[7:0];
`else
    assign rd_tail = 8'h00;
`endif

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        resp_d     = resp_q;
        left_d     = left_q;
        out_data_d = out_data_q;
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        if (rx_state) begin
            if (accept) begin
                timer_d = TimeoutLoad;
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
                chk_d = (state_q == StIdle) ? bus_io.in_data : chk_q ^ bus_io.in_data;
`endif
                if (bus_io.in_error != 2'b00) begin
                    state_d = StIdle;
                end else begin
                    case (state_q)
                        StIdle: begin
                            cnt_d = 2'd0;
                            if (bus_io.in_data == 8'h57 || bus_io.in_data == 8'h52) begin
                                op_wr_d = (bus_io.in_data == 8'h57);
                                state_d = StAddr;
                            end else begin
                                out_data_d = NAK_CODE;
                                left_d     = 3'd0;
                                state_d    = StResp;
                            end
                        end
                        StAddr: begin
                            addr_d = {addr_q[7:0], bus_io.in_data};
                            cnt_d  = cnt_q + 2'd1;
                            if (cnt_q == 2'd1) begin
                                cnt_d = 2'd0;
                                if (op_wr_q) state_d = StData;
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
                                else state_d = StChk;
`else
                                else state_d = StBus;
`endif
                            end
                        end
                        StData: begin
                            wdata_d = {wdata_q[23:0], bus_io.in_data};
                            cnt_d   = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) begin
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
                                state_d = StChk;
`else
                                state_d = StBus;
`endif
                            end
                        end
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
                        StChk: begin
                            if (bus_io.in_data == chk_q) begin
                                state_d = StBus;
                            end else begin
                                out_data_d = NAK_CODE;
                                left_d     = 3'd0;
                                state_d    = StResp;
                            end
                        end
`endif
                        default: state_d = StIdle;
                    endcase
                end
            end else if (state_q != StIdle) begin
                // Byte acceptance above wins over an expiring timer in the same cycle.
                if (timer_q == 24'd0) state_d = StIdle;
                else                  timer_d = timer_q - 24'd1;
            end
        end else if (state_q == StBus) begin
            if (!bus_io.avm_waitrequest) begin
                state_d = StResp;
                if (op_wr_q) begin
                    out_data_d = ACK_CODE;
                    left_d     = 3'd0;
                end else begin
                    out_data_d = bus_io.avm_readdata[31:24];
                    resp_d     = {bus_io.avm_readdata[23:0], rd_tail};
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
                    left_d     = 3'd4;
`else
                    left_d     = 3'd3;
`endif
                end
            end
        end else if (bus_io.out_ready) begin
            if (left_q == 3'd0) begin
                state_d = StIdle;
            end else begin
                out_data_d = resp_q[31:24];
                resp_d     = {resp_q[23:0], 8'h00};
                left_d     = left_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q    <= StIdle;
            op_wr_q    <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 32'h0;
            cnt_q      <= 2'd0;
            timer_q    <= 24'd0;
            resp_q     <= 32'h0;
            left_q     <= 3'd0;
            out_data_q <= 8'h00;
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            resp_q     <= resp_d;
            left_q     <= left_d;
            out_data_q <= out_data_d;
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign bus_io.in_ready       = rx_state;
    assign bus_io.busy           = (state_q != StIdle);
    assign bus_io.out_valid      = (state_q == StResp);
    assign bus_io.out_data       = out_data_q;
    assign bus_io.avm_address    = {addr_q, 2'b00};
    assign bus_io.avm_read       = (state_q == StBus) && !op_wr_q;
    assign bus_io.avm_write      = (state_q == StBus) && op_wr_q;
    assign bus_io.avm_writedata  = wdata_q;
    assign bus_io.avm_byteenable = 4'hF;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: stimulus pushes expected bus/response items,
// monitors pop and compare as the DUT presents them.
module tb_uart_cmd_responder;
    logic clock_sig = 1'b0;
    logic reset_sig = 1'b1;
    always #5 clock_sig = ~clock_sig;

    uart_cmd_responder_if bus_if ();

    uart_cmd_responder #(
        .TIMEOUT_CYCLES(100),
        .ACK_CODE      (8'h06),
        .NAK_CODE      (8'h15)
    ) dut (
        .clock_sig(clock_sig),
        .reset_sig(reset_sig),
        .bus_io   (bus_if.master)
    );

    typedef struct packed {
        logic        wr;
        logic [17:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        bus_q[$];
    logic [7:0]  byte_q[$];
    int          checks = 0;
    int          errors = 0;
    int          bus_count = 0;
    int          wait_n = 0;
    int          ready_mode = 0;
    logic [31:0] rd_value = 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Avalon slave model plus bus monitor.
    initial begin
        int   ws;
        bit   lat;
        bus_t e;
        ws = 0;
        lat = 0;
        bus_if.avm_waitrequest = 1'b1;
        bus_if.avm_readdata = 32'h0;
        forever begin
            @(negedge clock_sig);
            if (lat && !reset_sig) begin
                chk("resp_latency", bus_if.out_valid, 1);
                chk("strobe_drop", {bus_if.avm_read, bus_if.avm_write}, 0);
            end
            lat = 0;
            bus_if.avm_readdata = rd_value;
            if (reset_sig || !(bus_if.avm_read || bus_if.avm_write)) begin
                ws = 0;
                bus_if.avm_waitrequest = 1'b1;
            end else if (ws < wait_n) begin
                bus_if.avm_waitrequest = 1'b1;
                ws++;
            end else begin
                bus_if.avm_waitrequest = 1'b0;
                bus_count++;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got addr %h rd %b wr %b expected no access",
                             bus_if.avm_address, bus_if.avm_read, bus_if.avm_write);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_write", bus_if.avm_write, e.wr);
                    chk("bus_read", bus_if.avm_read, !e.wr);
                    chk("bus_addr", bus_if.avm_address, e.addr);
                    chk("bus_byteen", bus_if.avm_byteenable, 4'hF);
                    if (e.wr) chk("bus_wdata", bus_if.avm_writedata, e.data);
                end
                lat = 1;
            end
        end
    end

    // Response monitor: pops on each handshake, checks data holds while stalled.
    initial begin
        bit         hold;
        logic [7:0] hv;
        logic [7:0] e;
        hold = 0;
        hv = 8'h00;
        forever begin
            @(negedge clock_sig);
            if (!reset_sig && bus_if.out_valid) begin
                if (hold) chk("out_hold", bus_if.out_data, hv);
                if (bus_if.out_ready) begin
                    hold = 0;
                    if (byte_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got %h expected no byte", bus_if.out_data);
                    end else begin
                        e = byte_q.pop_front();
                        chk("resp_byte", bus_if.out_data, e);
                    end
                end else begin
                    hold = 1;
                    hv = bus_if.out_data;
                end
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clock_sig);
            #1;
            case (ready_mode)
                0:       bus_if.out_ready = 1'b1;
                1:       bus_if.out_ready = !bus_if.out_ready;
                default: bus_if.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input logic [1:0] err);
        int n;
        n = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data = b;
        bus_if.in_error = err;
        @(negedge clock_sig);
        while (!bus_if.in_ready && n < 1000) begin
            @(negedge clock_sig);
            n++;
        end
        if (!bus_if.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        @(posedge clock_sig);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_error = 2'b00;
    endtask

    task automatic send_write(input logic [15:0] a, input logic [31:0] d, input int ws,
                              input logic [17:0] exp_addr);
        logic [7:0] x;
        wait_n = ws;
        bus_q.push_back('{wr: 1'b1, addr: exp_addr, data: d});
        byte_q.push_back(8'h06);
        x = 8'h57 ^ a[15:8] ^ a[7:0] ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        send_byte(8'h57, 2'b00);
        send_byte(a[15:8], 2'b00);
        send_byte(a[7:0], 2'b00);
        send_byte(d[31:24], 2'b00);
        send_byte(d[23:16], 2'b00);
        send_byte(d[15:8], 2'b00);
        send_byte(d[7:0], 2'b00);
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
        send_byte(x, 2'b00);
`endif
    endtask

    task automatic send_read(input logic [15:0] a, input logic [31:0] rd, input int ws,
                             input logic [17:0] exp_addr);
        logic [7:0] x;
        rd_value = rd;
        wait_n = ws;
        bus_q.push_back('{wr: 1'b0, addr: exp_addr, data: 32'h0});
        byte_q.push_back(rd[31:24]);
        byte_q.push_back(rd[23:16]);
        byte_q.push_back(rd[15:8]);
        byte_q.push_back(rd[7:0]);
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
        byte_q.push_back(rd[31:24] ^ rd[23:16] ^ rd[15:8] ^ rd[7:0]);
`endif
        x = 8'h52 ^ a[15:8] ^ a[7:0];
        send_byte(8'h52, 2'b00);
        send_byte(a[15:8], 2'b00);
        send_byte(a[7:0], 2'b00);
`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
        send_byte(x, 2'b00);
`endif
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((byte_q.size() != 0 || bus_q.size() != 0 || bus_if.busy) && n < 2000) begin
            @(negedge clock_sig);
            n++;
        end
        chk("drain", byte_q.size() + bus_q.size(), 0);
        chk("idle_busy", bus_if.busy, 0);
        @(posedge clock_sig);
        #1;
    endtask

    initial begin
        int bc;
        int n;
        int sz;
        bus_if.in_valid = 1'b0;
        bus_if.in_data = 8'h00;
        bus_if.in_error = 2'b00;
        reset_sig = 1'b1;
        repeat (3) @(negedge clock_sig);
        reset_sig = 1'b0;
        @(negedge clock_sig);
        chk("rst_in_ready", bus_if.in_ready, 1);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_out_data", bus_if.out_data, 0);
        chk("rst_avm_read", bus_if.avm_read, 0);
        chk("rst_avm_write", bus_if.avm_write, 0);
        chk("rst_avm_address", bus_if.avm_address, 0);
        chk("rst_avm_writedata", bus_if.avm_writedata, 0);
        chk("rst_byteenable", bus_if.avm_byteenable, 4'hF);
        @(posedge clock_sig);
        #1;

        // Write with 3 wait states.
        send_write(16'h0010, 32'hDEADBEEF, 3, 18'h00040);
        wait_done();

        // Read with out_ready toggling.
        ready_mode = 1;
        send_read(16'h1234, 32'h01020304, 0, 18'h048D0);
        wait_done();
        ready_mode = 0;

        // Top address wraps into the 18-bit byte address.
        send_write(16'hFFFF, 32'h00C0FFEE, 1, 18'h3FFFC);
        wait_done();

        // Unknown opcode.
        bc = bus_count;
        byte_q.push_back(8'h15);
        send_byte(8'h41, 2'b00);
        wait_done();
        chk("nak_no_bus", bus_count, bc);

        // Inter-byte timeout.
        bc = bus_count;
        send_byte(8'h57, 2'b00);
        send_byte(8'h00, 2'b00);
        repeat (50) @(negedge clock_sig);
        chk("timeout_busy_mid", bus_if.busy, 1);
        repeat (60) @(negedge clock_sig);
        chk("timeout_busy_end", bus_if.busy, 0);
        chk("timeout_no_bus", bus_count, bc);
        @(posedge clock_sig);
        #1;
        send_read(16'h0000, 32'hA55A0FF0, 1, 18'h00000);
        wait_done();

        // Framing error on second byte.
        bc = bus_count;
        send_byte(8'h52, 2'b00);
        send_byte(8'h00, 2'b10);
        @(negedge clock_sig);
        chk("rxerr_busy", bus_if.busy, 0);
        repeat (5) @(negedge clock_sig);
        chk("rxerr_no_bus", bus_count, bc);
        @(posedge clock_sig);
        #1;

        // Reset during the second response byte.
        send_read(16'h0003, 32'hCAFEF00D, 0, 18'h0000C);
        sz = byte_q.size();
        n = 0;
        while (byte_q.size() == sz && n < 1000) begin
            @(negedge clock_sig);
            #1;
            n++;
        end
        ready_mode = 2;
        repeat (2) @(negedge clock_sig);
        chk("mid_resp_valid", bus_if.out_valid, 1);
        chk("mid_resp_byte2", bus_if.out_data, 8'hFE);
        #2;
        reset_sig = 1'b1;
        #1;
        chk("rst_mid_out_valid", bus_if.out_valid, 0);
        chk("rst_mid_busy", bus_if.busy, 0);
        chk("rst_mid_out_data", bus_if.out_data, 0);
        byte_q.delete();
        ready_mode = 0;
        @(negedge clock_sig);
        reset_sig = 1'b0;
        @(posedge clock_sig);
        #1;
        send_write(16'h0002, 32'h12345678, 0, 18'h00008);
        wait_done();

`ifdef UART_CMD_RESPONDER_CHECKSUM_EN
        // 52 00 01 53: checksum matches.
        send_read(16'h0001, 32'h11223344, 2, 18'h00004);
        wait_done();
        // 52 00 01 00: checksum mismatch.
        bc = bus_count;
        byte_q.push_back(8'h15);
        send_byte(8'h52, 2'b00);
        send_byte(8'h00, 2'b00);
        send_byte(8'h01, 2'b00);
        send_byte(8'h00, 2'b00);
        wait_done();
        chk("chk_nak_no_bus", bus_count, bc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
